// File: rtl/fmul_sched_pkg.sv
// Shared widths, constants and FSM state type for the fmul_sched block.
package fmul_pkg;

  localparam int WORD_W = 10;
  localparam int FRAC_W = 6;
  localparam int EXP_W  = 4;

  // Result returned when either operand has a zero fraction.
  localparam logic [WORD_W-1:0] ZERO_WORD = 10'b000000_1000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } sched_state_t;

  // True when the fraction field (top FRAC_W bits) of a word is all zero.
  function automatic logic frac_is_zero(input logic [WORD_W-1:0] w);
    return (w[WORD_W-1 -: FRAC_W] == '0);
  endfunction

endpackage

// File: rtl/fmul_sched_if.sv
// Request/response bundle between the two requesters and the scheduler.
//
// Handshake rule for both channels: a transfer happens on a rising edge where
// valid and ready are both high. Once a response is valid it stays valid with
// stable data until accepted. req_ready is one-hot and may depend on req_valid
// in the same cycle; the requester must not make req_valid depend on req_ready.
interface fmul_sched_if;
  import fmul_pkg::*;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [WORD_W-1:0] req_a0;
  logic [WORD_W-1:0] req_b0;
  logic [WORD_W-1:0] req_a1;
  logic [WORD_W-1:0] req_b1;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [WORD_W-1:0] rsp_f;
  logic              rsp_ovf;
  logic              rsp_udf;
  logic              rsp_err;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_f, rsp_ovf, rsp_udf, rsp_err
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_f, rsp_ovf, rsp_udf, rsp_err
  );

endinterface

// File: rtl/fmul_sched_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester other than
// 'last' wins. Purely combinational; the caller owns the 'last' register.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  // One-hot grant, all zero when disabled or nothing is requested.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/fmul_sched.sv
// Scheduler for a shared floating-point multiplier: arbitrates two
// requesters, drives load/start, waits for done with a timeout, and returns
// a tagged response. Zero-fraction operands bypass the multiplier.
module fmul_sched
  import fmul_pkg::*;
#(
  parameter int TMO = 32
) (
  input  logic              clk,
  input  logic              rst,
  fmul_sched_if.slave       bus,
  output logic              mul_rstn,
  output logic              mul_load,
  output logic              mul_start,
  output logic [WORD_W-1:0] mul_a,
  output logic [WORD_W-1:0] mul_b,
  input  logic [WORD_W-1:0] mul_f,
  input  logic              mul_done,
  input  logic              mul_ovf,
  input  logic              mul_udf,
  output sched_state_t      dbg_state
);

  localparam int CNT_W = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);

  sched_state_t      r_state;
  sched_state_t      w_next;
  logic              r_last;
  logic              r_id;
  logic [WORD_W-1:0] r_a;
  logic [WORD_W-1:0] r_b;
  logic [WORD_W-1:0] r_rsp_f;
  logic              r_ovf;
  logic              r_udf;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic [1:0]        w_gnt;
  logic              w_accept;
  logic              w_sel;
  logic [WORD_W-1:0] w_op_a;
  logic [WORD_W-1:0] w_op_b;
  logic              w_bypass;
  logic              w_tmo_hit;

  rr_arb2 u_arb (
    .req  (bus.req_valid),
    .last (r_last),
    .en   (r_state == IDLE),
    .gnt  (w_gnt)
  );

  assign w_accept  = |(w_gnt & bus.req_valid);
  assign w_sel     = w_gnt[1];
  assign w_op_a    = w_sel ? bus.req_a1 : bus.req_a0;
  assign w_op_b    = w_sel ? bus.req_b1 : bus.req_b0;
  assign w_bypass  = frac_is_zero(w_op_a) | frac_is_zero(w_op_b);
  assign w_tmo_hit = (r_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; done has priority over a same-cycle timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_bypass ? RESP : LOAD;
      LOAD:    w_next = START;
      START:   w_next = WAIT;
      WAIT:    if (mul_done || w_tmo_hit) w_next = RESP;
      RESP:    if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, arbitration history, timeout counter and response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_rsp_f <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_a    <= w_op_a;
        r_b    <= w_op_b;
        r_id   <= w_sel;
        r_last <= w_sel;
        if (w_bypass) begin
          r_rsp_f <= ZERO_WORD;
          r_ovf   <= 1'b0;
          r_udf   <= 1'b0;
          r_err   <= 1'b0;
        end
      end
      if (r_state == START) begin
        r_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + 1'b1;
        if (mul_done) begin
          r_rsp_f <= mul_f;
          r_ovf   <= mul_ovf;
          r_udf   <= mul_udf;
          r_err   <= 1'b0;
        end else if (w_tmo_hit) begin
          r_rsp_f <= '0;
          r_ovf   <= 1'b0;
          r_udf   <= 1'b0;
          r_err   <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = w_gnt;
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_f     = r_rsp_f;
  assign bus.rsp_ovf   = r_ovf;
  assign bus.rsp_udf   = r_udf;
  assign bus.rsp_err   = r_err;

  assign mul_rstn  = ~rst;
  assign mul_load  = (r_state == LOAD);
  assign mul_start = (r_state == START);
  assign mul_a     = r_a;
  assign mul_b     = r_b;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fmul_sched.sv
// Directed bench for fmul_sched with a small behavioural multiplier model.
module tb_fmul_sched;
  import fmul_pkg::*;

  localparam int TMO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  fmul_sched_if bus ();
  logic         mul_rstn, mul_load, mul_start;
  logic [9:0]   mul_a, mul_b, mul_f;
  logic         mul_done, mul_ovf, mul_udf;
  sched_state_t dbg_state;

  fmul_sched #(.TMO(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mul_rstn  (mul_rstn),
    .mul_load  (mul_load),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_f     (mul_f),
    .mul_done  (mul_done),
    .mul_ovf   (mul_ovf),
    .mul_udf   (mul_udf),
    .dbg_state (dbg_state)
  );

  // ---------------- multiplier model ----------------
  // Returns the A operand latched at start, 'm_delay' cycles after start.
  int         m_delay = 3;
  bit         m_ovf = 0, m_udf = 0, m_hang = 0, force_done = 0;
  int         m_cnt = 0;
  logic [9:0] m_a = '0;

  always @(negedge clk) begin
    mul_done = 1'b0; mul_ovf = 1'b0; mul_udf = 1'b0; mul_f = '0;
    if (force_done) begin
      mul_done = 1'b1; mul_f = 10'h3ff; mul_ovf = 1'b1; mul_udf = 1'b1;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        mul_done = 1'b1; mul_f = m_a; mul_ovf = m_ovf; mul_udf = m_udf;
      end
    end
    if (mul_start && !m_hang) begin
      m_cnt = m_delay;
      m_a   = mul_a;
    end
    if (rst) m_cnt = 0;
  end

  // Pulse monitor.
  int n_load = 0, n_start = 0, load_cyc = -1, start_cyc = -1;
  always @(negedge clk) begin
    if (mul_load)  begin n_load++;  load_cyc  = cyc; end
    if (mul_start) begin n_start++; start_cyc = cyc; end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left at negedge+1.
  task automatic issue(input int id, input logic [9:0] a, input logic [9:0] b,
                       output int t, output bit ok);
    if (id == 0) begin bus.req_a0 = a; bus.req_b0 = b; end
    else         begin bus.req_a1 = a; bus.req_b1 = b; end
    bus.req_valid[id] = 1'b1;
    ok = 0; t = -1;
    #1;
    for (int k = 0; k < 30; k++) begin
      if (bus.req_ready[id]) begin t = cyc; ok = 1; break; end
      @(negedge clk); #2;
    end
    @(negedge clk); #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int t, output int lat, output bit ok);
    ok = 0; lat = -1;
    for (int k = 0; k < 60; k++) begin
      if (bus.rsp_valid) begin lat = cyc - t; ok = 1; break; end
      @(negedge clk); #1;
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int         id;
    logic [9:0] a, b;
    int         delay;
    bit         ovf, udf;
    logic [9:0] exp_f;
    bit         exp_ovf, exp_udf;
    int         exp_lat;
    int         exp_pulses;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int         t, lat, got;
    bit         ok;
    int         nl, ns;
    logic [9:0] ca0, ca1;

    bus.req_valid = 2'b00;
    bus.req_a0 = '0; bus.req_b0 = '0; bus.req_a1 = '0; bus.req_b1 = '0;
    bus.rsp_ready = 1'b1;

    //               id  a              b              dly ovf udf exp_f          eo eu lat p
    vecs[0] = '{0, 10'b010000_0001, 10'b010000_0001, 3, 0, 0, 10'b010000_0001, 0, 0, 6, 1};
    vecs[1] = '{1, 10'b010000_0101, 10'b010000_0101, 1, 1, 0, 10'b010000_0101, 1, 0, 4, 1};
    vecs[2] = '{0, 10'b010000_1010, 10'b010000_1010, 2, 0, 1, 10'b010000_1010, 0, 1, 5, 1};
    vecs[3] = '{1, 10'b000000_0011, 10'b010000_0010, 3, 0, 0, 10'b000000_1000, 0, 0, 1, 0};
    vecs[4] = '{0, 10'b010000_0001, 10'b000000_0101, 3, 0, 0, 10'b000000_1000, 0, 0, 1, 0};
    vecs[5] = '{1, 10'b100000_0011, 10'b011000_1110, 5, 0, 0, 10'b100000_0011, 0, 0, 8, 1};

    // ---- reset values ----
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_mul_rstn", 32'(mul_rstn), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_f", 32'(bus.rsp_f), 0);
    check("rst_rsp_id", 32'(bus.rsp_id), 0);
    check("rst_flags", 32'({bus.rsp_ovf, bus.rsp_udf, bus.rsp_err}), 0);
    check("rst_pulses", 32'({mul_load, mul_start}), 0);
    check("rst_mul_ab", 32'({mul_a, mul_b}), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("mul_rstn_released", 32'(mul_rstn), 1);

    // ---- table-driven single requests ----
    foreach (vecs[i]) begin
      m_delay = vecs[i].delay; m_ovf = vecs[i].ovf; m_udf = vecs[i].udf; m_hang = 0;
      nl = n_load; ns = n_start;
      issue(vecs[i].id, vecs[i].a, vecs[i].b, t, ok);
      check($sformatf("v%0d_accept", i), 32'(ok), 1);
      wait_rsp(t, lat, ok);
      check($sformatf("v%0d_rsp_seen", i), 32'(ok), 1);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_rsp_f", i), 32'(bus.rsp_f), 32'(vecs[i].exp_f));
      check($sformatf("v%0d_rsp_id", i), 32'(bus.rsp_id), 32'(vecs[i].id));
      check($sformatf("v%0d_ovf", i), 32'(bus.rsp_ovf), 32'(vecs[i].exp_ovf));
      check($sformatf("v%0d_udf", i), 32'(bus.rsp_udf), 32'(vecs[i].exp_udf));
      check($sformatf("v%0d_err", i), 32'(bus.rsp_err), 0);
      check($sformatf("v%0d_mul_a", i), 32'(mul_a), 32'(vecs[i].a));
      check($sformatf("v%0d_mul_b", i), 32'(mul_b), 32'(vecs[i].b));
      @(negedge clk); #1;
      check($sformatf("v%0d_rsp_dropped", i), 32'(bus.rsp_valid), 0);
      check($sformatf("v%0d_load_pulses", i), 32'(n_load - nl), 32'(vecs[i].exp_pulses));
      check($sformatf("v%0d_start_pulses", i), 32'(n_start - ns), 32'(vecs[i].exp_pulses));
      if (vecs[i].exp_pulses != 0) begin
        check($sformatf("v%0d_load_cyc", i), 32'(load_cyc), 32'(t + 1));
        check($sformatf("v%0d_start_cyc", i), 32'(start_cyc), 32'(t + 2));
      end
    end

    // ---- contention: both valid, alternating owners ----
    ca0 = 10'b010000_0001;
    ca1 = 10'b011000_0010;
    m_delay = 2; m_ovf = 0; m_udf = 0; m_hang = 0;
    bus.req_a0 = ca0; bus.req_b0 = ca0; bus.req_a1 = ca1; bus.req_b1 = ca1;
    bus.req_valid = 2'b11;
    got = 0;
    for (int k = 0; k < 200 && got < 4; k++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid && bus.rsp_ready) begin
        check($sformatf("cont%0d_id", got), 32'(bus.rsp_id), 32'(got % 2));
        check($sformatf("cont%0d_f", got), 32'(bus.rsp_f), 32'((got % 2) ? ca1 : ca0));
        check($sformatf("cont%0d_mul_a", got), 32'(mul_a), 32'((got % 2) ? ca1 : ca0));
        got++;
        if (got == 4) bus.req_valid = 2'b00;
      end
    end
    bus.req_valid = 2'b00;
    check("cont_count", 32'(got), 4);
    @(negedge clk); #1;

    // ---- timeout with backpressure and a late done ----
    m_hang = 1;
    bus.rsp_ready = 1'b0;
    issue(0, 10'b010000_0001, 10'b010000_0001, t, ok);
    check("tmo_accept", 32'(ok), 1);
    wait_rsp(t, lat, ok);
    check("tmo_rsp_seen", 32'(ok), 1);
    check("tmo_latency", 32'(lat), 32'(TMO + 3));
    check("tmo_err", 32'(bus.rsp_err), 1);
    check("tmo_f", 32'(bus.rsp_f), 0);
    check("tmo_flags", 32'({bus.rsp_ovf, bus.rsp_udf}), 0);
    check("tmo_id", 32'(bus.rsp_id), 0);
    for (int k = 0; k < 5; k++) begin
      force_done = (k == 1);
      @(negedge clk); #1;
      check($sformatf("hold%0d_valid", k), 32'(bus.rsp_valid), 1);
      check($sformatf("hold%0d_data", k), 32'({bus.rsp_f, bus.rsp_err, bus.rsp_ovf, bus.rsp_udf}),
            32'({10'd0, 1'b1, 1'b0, 1'b0}));
    end
    force_done = 0;
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("tmo_consumed", 32'(bus.rsp_valid), 0);
    check("tmo_idle", 32'(dbg_state), 32'(IDLE));
    repeat (3) @(negedge clk);
    #1;
    check("tmo_no_extra_rsp", 32'(bus.rsp_valid), 0);

    // ---- reset mid-WAIT ----
    issue(0, 10'b010000_0001, 10'b010000_0011, t, ok);
    check("rw_accept", 32'(ok), 1);
    repeat (3) @(negedge clk);
    #1;
    check("rw_in_wait", 32'(dbg_state), 32'(WAIT));
    rst = 1'b1;
    @(negedge clk); #1;
    check("rw_state", 32'(dbg_state), 32'(IDLE));
    check("rw_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rw_rsp_f_id", 32'({bus.rsp_f, bus.rsp_id}), 0);
    check("rw_flags", 32'({bus.rsp_ovf, bus.rsp_udf, bus.rsp_err}), 0);
    check("rw_pulses", 32'({mul_load, mul_start}), 0);
    check("rw_mul_ab", 32'({mul_a, mul_b}), 0);
    check("rw_mul_rstn", 32'(mul_rstn), 0);
    rst = 1'b0;
    got = 0;
    for (int k = 0; k < TMO + 6; k++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid) got++;
    end
    check("rw_no_rsp", 32'(got), 0);

    m_hang = 0; m_delay = 1;
    ca0 = 10'b011100_0001;
    ca1 = 10'b010100_0010;
    bus.req_a0 = ca0; bus.req_b0 = ca0; bus.req_a1 = ca1; bus.req_b1 = ca1;
    bus.req_valid = 2'b11;
    #1;
    check("rw_grant0", 32'(bus.req_ready), 32'(2'b01));
    t = cyc;
    @(negedge clk); #1;
    bus.req_valid = 2'b00;
    wait_rsp(t, lat, ok);
    check("rw_rsp_seen", 32'(ok), 1);
    check("rw_rsp_id", 32'(bus.rsp_id), 0);
    check("rw_rsp_f", 32'(bus.rsp_f), 32'(ca0));
    check("rw_latency", 32'(lat), 4);
    @(negedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fmul_sched.md
# fmul_sched

Two-requester scheduler for the shared 10-bit floating-point multiplier `mut` (6-bit two's-complement fraction, 4-bit two's-complement exponent). It arbitrates round-robin between two operand sources and sequences the multiplier's load/start/done protocol. It returns product and ovf/udf flags on a single tagged response channel. It also bypasses zero-mantissa operands and times out a hung multiplier.

## Interface
- `TMO`, 32: cycles allowed in WAIT before a timeout error response (≥4).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: per-requester operand request.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in 10 each: operands per requester.
- `req_ready` out 2: one-hot accept; the request is taken on `req_valid[i] & req_ready[i]`.
- `rsp_valid` out 1: response valid, held until accepted.
- `rsp_ready` in 1: response accept.
- `rsp_id` out 1: index of the requester that owns the response.
- `rsp_f` out 10: product.
- `rsp_ovf`, `rsp_udf`, `rsp_err` out 1 each: flags copied from the multiplier, plus timeout.
- `mul_rstn` out 1: `~rst`, drives the multiplier reset.
- `mul_load`, `mul_start` out 1: one-cycle pulses to the multiplier.
- `mul_a`, `mul_b` out 10: captured operands, stable from LOAD through WAIT.
- `mul_f` in 10, `mul_done` in 1, `mul_ovf` in 1, `mul_udf` in 1: multiplier results.

## Operation
- States are IDLE, LOAD, START, WAIT, RESP.
- **IDLE:** `req_ready` is combinational. If only one `req_valid` is set, grant it. If both are set, grant the requester other than `last` (`last` resets to 1, so requester 0 wins first).
- **On accept:** capture operands into `mul_a`/`mul_b`, set `id`, and set `last`=`id`.
- **Zero bypass:** if either captured fraction [9:4] is 000000, go straight to RESP with `rsp_f`=000000_1000, all flags 0. The multiplier is not touched.
- **Normal path, LOAD:** `mul_load`=1 for one cycle. **START:** `mul_start`=1 for one cycle. **WAIT:** the timeout counter is cleared on entry and increments each cycle.
- **Leaving WAIT on done:** the first cycle with `mul_done`=1 registers `mul_f`/`mul_ovf`/`mul_udf` into the response registers, `rsp_err`=0, and moves to RESP.
- **Leaving WAIT on timeout:** if the counter reaches TMO-1 with no done, go to RESP with `rsp_f`=0, `rsp_err`=1, ovf/udf=0.
- **RESP:** `rsp_valid`=1 with data stable; on `rsp_ready` go to IDLE. `req_ready`=0 in every state except IDLE.
- `mul_done` outside WAIT is ignored, including a late done after a timeout.
- A requester that drops `req_valid` before grant loses nothing; no request is queued internally.
- Flags from the multiplier are passed through unmodified; the scheduler does no exponent arithmetic.

## Timing
- **Reset values:** state=IDLE, `req_ready`=00, `rsp_valid`=0, `rsp_f`=0, all flags 0, `rsp_id`=0, `mul_load`=`mul_start`=0, `mul_a`=`mul_b`=0, `last`=1.
- **Reset mid-operation** (any state): return to the reset values on the next edge. Any in-flight result is dropped and no response is issued.
- **Accept at cycle T:** LOAD at T+1, START at T+2, WAIT from T+3.
- **Done seen at cycle D:** `rsp_valid` rises at D+1.
- **Bypass:** `rsp_valid` at T+1.
- **Timeout:** `rsp_valid` at T+3+TMO.
- **Back-to-back:** `rsp_ready` is high in the first RESP cycle, so IDLE is at the next edge and a new accept is possible that cycle. Minimum issue interval is therefore LOAD..RESP latency + 1.
- **Simultaneous requests:** the loser keeps `req_valid` high and is granted at the next IDLE.

## Structure
- Package `fmul_pkg` holds:
  - `WORD_W`=10, `FRAC_W`=6, `EXP_W`=4.
  - `ZERO_WORD`=10'b000000_1000.
  - State enum `sched_state_t` (IDLE, LOAD, START, WAIT, RESP).
- Sub-module `rr_arb2` is purely combinational. It takes `req[1:0]`, `last`, `en` and produces a one-hot `gnt[1:0]`. The top holds the `last` register.
- The top holds the FSM, operand and response registers, and the timeout counter (width clog2(TMO)).

## Test plan
- **Single request:** req0, A=B=010000_0001, model done 3 cycles after start → `rsp_f`=010000_0001, `rsp_id`=0, ovf=udf=err=0. `mul_load` at T+1 and `mul_start` at T+2 each high exactly one cycle.
- **Contention:** both valid continuously, 4 responses → `rsp_id` sequence 0,1,0,1 with operands matching the owner of each response.
- **Flags:** A=B=010000_0101 with model ovf=1 → `rsp_ovf`=1. A=B=010000_1010 with model udf=1 → `rsp_udf`=1.
- **Zero bypass:** A=000000_0011, B=010000_0010 → `rsp_f`=000000_1000 at T+1, no `mul_load`/`mul_start` pulse.
- **Timeout and backpressure:** model never asserts done, TMO=8 → `rsp_err`=1, `rsp_f`=0 at T+11. With `rsp_ready` low for 5 cycles the response stays stable. A late `mul_done` is ignored.
- **Reset mid-WAIT:** `rst` high 1 cycle → all outputs at reset values next cycle, no response issued, and the next simultaneous request grants requester 0.
